pixel_compositor: RTL and testbench

Final per-pixel stage of the video path: merges the background, sprite and game-over overlay layers into one 12-bit RGB stream. It realigns the VGA sync signals with the one-cycle-late ROM colour data and registers everything for the VGA pins. It also owns the game-over presentation state machine, which makes the overlay blink for a fixed number of frames and then hold steady. Sits between the per-layer `*_display` blocks (e.g. `game_over_display`) and the top-level VGA outputs.

---
 rtl/video_pkg.sv | 19 +
 rtl/pixel_compositor_if.sv | 33 +++
 rtl/pixel_compositor_sync_delay.sv | 32 +++
 rtl/pixel_compositor.sv | 148 ++++++++++++++
 tb/tb_pixel_compositor.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// Shared video-path definitions: presentation state encoding, colour width and constants.
package video_pkg;

    localparam int RGB_W = 12;
    localparam logic [RGB_W-1:0] RGB_BLACK    = 12'h000;
    localparam logic [RGB_W-1:0] RGB_DIM_MASK = 12'h777;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        BLINK = 2'd1,
        HOLD  = 2'd2
    } go_state_t;

    // Halve each 4-bit channel; the mask drops bits shifted in from the neighbouring channel.
    function automatic logic [RGB_W-1:0] dim_rgb(input logic [RGB_W-1:0] c);
        return (c >> 1) & RGB_DIM_MASK;
    endfunction

endpackage

// File: rtl/pixel_compositor_if.sv
// Pixel-path bundle between the layer display blocks and the compositor.
// master = layer/timing side that drives pixels, slave = pixel_compositor.
interface pixel_compositor_if;

    logic                        video_on_in;
    logic                        hsync_in;
    logic                        vsync_in;
    logic                        game_over;
    logic [video_pkg::RGB_W-1:0] bg_rgb;
    logic [video_pkg::RGB_W-1:0] coin_rgb;
    logic                        coin_on;
    logic [video_pkg::RGB_W-1:0] mario_rgb;
    logic                        mario_on;
    logic [video_pkg::RGB_W-1:0] go_rgb;
    logic                        go_on;
    logic [video_pkg::RGB_W-1:0] rgb;
    logic                        hsync;
    logic                        vsync;
    logic [1:0]                  go_state;

    modport master (
        output video_on_in, hsync_in, vsync_in, game_over,
        output bg_rgb, coin_rgb, coin_on, mario_rgb, mario_on, go_rgb, go_on,
        input  rgb, hsync, vsync, go_state
    );

    modport slave (
        input  video_on_in, hsync_in, vsync_in, game_over,
        input  bg_rgb, coin_rgb, coin_on, mario_rgb, mario_on, go_rgb, go_on,
        output rgb, hsync, vsync, go_state
    );

endinterface

// File: rtl/pixel_compositor_sync_delay.sv
// sync_delay: DEPTH-stage shift register for the timing flags, with a per-bit reset value
// so that syncs come out of reset inactive (high) and video_on comes out low.
module sync_delay #(
    parameter int                DEPTH     = 1,
    parameter int                WIDTH     = 3,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    // Shift the flags one stage per pixel clock; reset fills every stage with RESET_VAL.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= RESET_VAL;
            end
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/pixel_compositor.sv
// pixel_compositor: merges background, coin, Mario and game-over overlay layers into the
// registered 12-bit VGA pixel, realigns the syncs with the late ROM colour data and runs the
// game-over blink/hold presentation state machine.
// Optional build macro PIXEL_COMPOSITOR_DIM_EN: halves every non-overlay pixel while the
// game-over presentation is active.
module pixel_compositor import video_pkg::*; #(
    parameter int SYNC_LAT      = 1,
    parameter int BLINK_FRAMES  = 30,
    parameter int BLINK_TOGGLES = 6
) (
    input  logic               clk,
    input  logic               rst,
    pixel_compositor_if.slave  vid
);

    localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int TCNT_W = $clog2(BLINK_TOGGLES + 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(BLINK_TOGGLES - 1);

    logic              video_on_d;
    logic              hsync_d;
    logic              vsync_d;
    logic              vsync_prev;
    logic              fs;
    go_state_t         state;
    logic              vis;
    logic [FCNT_W-1:0] fcnt;
    logic [TCNT_W-1:0] tcnt;
    logic [RGB_W-1:0]  layer_rgb;
    logic [RGB_W-1:0]  pixel_next;

    sync_delay #(
        .DEPTH     (SYNC_LAT),
        .WIDTH     (3),
        .RESET_VAL (3'b011)
    ) u_sync_delay (
        .clk  (clk),
        .rst  (rst),
        .din  ({vid.video_on_in, vid.hsync_in, vid.vsync_in}),
        .dout ({video_on_d, hsync_d, vsync_d})
    );

    // Remember last vsync_in so its falling edge marks the start of a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_prev <= 1'b1;
        end else begin
            vsync_prev <= vid.vsync_in;
        end
    end

    assign fs = vsync_prev & ~vid.vsync_in;

    // Presentation state machine; only moves at frame start so a frame never changes mid-scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PLAY;
            vis   <= 1'b0;
            fcnt  <= '0;
            tcnt  <= '0;
        end else if (fs) begin
            case (state)
                PLAY: begin
                    if (vid.game_over) begin
                        state <= BLINK;
                        vis   <= 1'b1;
                        fcnt  <= '0;
                        tcnt  <= '0;
                    end
                end
                BLINK: begin
                    if (!vid.game_over) begin
                        state <= PLAY;
                        vis   <= 1'b0;
                        fcnt  <= '0;
                        tcnt  <= '0;
                    end else if (fcnt == FCNT_LAST) begin
                        fcnt <= '0;
                        tcnt <= tcnt + TCNT_W'(1);
                        if (tcnt == TCNT_LAST) begin
                            state <= HOLD;
                            vis   <= 1'b1;
                        end else begin
                            vis <= ~vis;
                        end
                    end else begin
                        fcnt <= fcnt + FCNT_W'(1);
                    end
                end
                HOLD: begin
                    if (!vid.game_over) begin
                        state <= PLAY;
                        vis   <= 1'b0;
                        fcnt  <= '0;
                        tcnt  <= '0;
                    end else begin
                        vis <= 1'b1;
                    end
                end
                default: begin
                    state <= PLAY;
                    vis   <= 1'b0;
                    fcnt  <= '0;
                    tcnt  <= '0;
                end
            endcase
        end
    end

    // Layer priority: blanking, visible overlay, Mario, coin, then background.
    always_comb begin
        layer_rgb  = vid.bg_rgb;
        pixel_next = RGB_BLACK;
        if (vid.mario_on) begin
            layer_rgb = vid.mario_rgb;
        end else if (vid.coin_on) begin
            layer_rgb = vid.coin_rgb;
        end
        if (!video_on_d) begin
            pixel_next = RGB_BLACK;
        end else if (vis && vid.go_on) begin
            pixel_next = vid.go_rgb;
        end else begin
`ifdef PIXEL_COMPOSITOR_DIM_EN
            pixel_next = (state != PLAY) ? dim_rgb(layer_rgb) : layer_rgb;
`else
            pixel_next = layer_rgb;
`endif
        end
    end

    // Register the pixel and the realigned syncs for the VGA pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            vid.rgb   <= RGB_BLACK;
            vid.hsync <= 1'b1;
            vid.vsync <= 1'b1;
        end else begin
            vid.rgb   <= pixel_next;
            vid.hsync <= hsync_d;
            vid.vsync <= vsync_d;
        end
    end

    assign vid.go_state = state;

endmodule

// File: tb/tb_pixel_compositor.sv
// tb_pixel_compositor: frame-table vectors, hand-written reset/game-over sequences and
// random frames, all checked against a frame-level behavioural model of the compositor.
module tb_pixel_compositor;
    import video_pkg::*;

    localparam int SYNC_LAT = 2;
    localparam int BF       = 2;
    localparam int BT       = 6;
    localparam int H_TOT    = 16;
    localparam int H_ACT    = 12;
    localparam int V_TOT    = 8;
    localparam int V_ACT    = 6;
    localparam int NV       = 20;

`ifdef PIXEL_COMPOSITOR_DIM_EN
    localparam bit          DIM_ON      = 1'b1;
    localparam logic [11:0] BG_BLINK    = 12'h154;
    localparam logic [11:0] MARIO_BLINK = 12'h700;
`else
    localparam bit          DIM_ON      = 1'b0;
    localparam logic [11:0] BG_BLINK    = 12'h3B9;
    localparam logic [11:0] MARIO_BLINK = 12'hF00;
`endif

    typedef struct packed {
        logic        video_on;
        logic        hsync;
        logic        vsync;
        logic        game_over;
        logic [11:0] bg;
        logic [11:0] coin;
        logic [11:0] mario;
        logic [11:0] go;
        logic        coin_on;
        logic        mario_on;
        logic        go_on;
    } pin_t;

    typedef struct {
        logic [11:0] bg;
        logic [11:0] coin;
        logic        coin_on;
        logic [11:0] mario;
        logic        mario_on;
        logic [11:0] go;
        logic        go_on;
        logic        game_over;
        logic [11:0] exp_rgb;
        logic [1:0]  exp_state;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_fail = 0;
    vec_t fix;
    vec_t tbl [NV];
    logic go_level = 1'b0;

    bit          m_valid = 1'b0;
    bit          m_in_game;
    int          m_k;
    bit          m_prev_vs;
    pin_t        hist [$];
    logic [11:0] e_rgb;
    logic        e_hs;
    logic        e_vs;
    logic [1:0]  e_state;
    int          cyc = 0;
    int          hs_fall_cyc = -1;
    logic        prev_hs_in = 1'b1;
    logic        prev_hs_out = 1'b1;

    pixel_compositor_if vid ();

    pixel_compositor #(
        .SYNC_LAT      (SYNC_LAT),
        .BLINK_FRAMES  (BF),
        .BLINK_TOGGLES (BT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vid (vid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic vec_t mkVec(input logic [11:0] bg, input logic [11:0] coin, input logic coin_on,
                                   input logic [11:0] mario, input logic mario_on, input logic [11:0] go,
                                   input logic go_on, input logic game_over, input logic [11:0] exp_rgb,
                                   input logic [1:0] exp_state);
        vec_t v;
        v.bg = bg; v.coin = coin; v.coin_on = coin_on; v.mario = mario; v.mario_on = mario_on;
        v.go = go; v.go_on = go_on; v.game_over = game_over; v.exp_rgb = exp_rgb; v.exp_state = exp_state;
        return v;
    endfunction

    // Reference model: overlay visibility and state derived from the number of frame starts
    // since the game ended.
    function automatic logic modelVis(input bit in_game, input int k);
        return in_game && ((k >= BF * BT) || (((k / BF) % 2) == 0));
    endfunction

    function automatic logic [1:0] modelState(input bit in_game, input int k);
        if (!in_game) return 2'd0;
        return (k >= BF * BT) ? 2'd2 : 2'd1;
    endfunction

    function automatic logic [11:0] halve(input logic [11:0] c);
        logic [11:0] r;
        logic [3:0]  n;
        for (int ch = 0; ch < 3; ch++) begin
            n = c[ch*4 +: 4];
            r[ch*4 +: 4] = n >> 1;
        end
        return r;
    endfunction

    function automatic logic [11:0] refPixel(input logic von, input logic vis, input logic [1:0] st, input pin_t p);
        logic [11:0] c;
        if (!von) return 12'h000;
        if (vis && p.go_on) return p.go;
        c = p.mario_on ? p.mario : (p.coin_on ? p.coin : p.bg);
        if (DIM_ON && st != 2'd0) c = halve(c);
        return c;
    endfunction

    // Monitor: advance the model at every edge and compare all outputs 1 time unit later.
    always @(posedge clk) begin
        pin_t s;
        pin_t d;
        cyc++;
        s = '{vid.video_on_in, vid.hsync_in, vid.vsync_in, vid.game_over, vid.bg_rgb, vid.coin_rgb,
              vid.mario_rgb, vid.go_rgb, vid.coin_on, vid.mario_on, vid.go_on};
        if (rst) begin
            m_valid   = 1'b1;
            m_in_game = 1'b0;
            m_k       = 0;
            m_prev_vs = 1'b1;
            hist.delete();
            d = '0;
            d.hsync = 1'b1;
            d.vsync = 1'b1;
            for (int i = 0; i < SYNC_LAT; i++) hist.push_back(d);
            e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1; e_state = 2'd0;
            hs_fall_cyc = -1;
        end else if (m_valid) begin
            d = hist.pop_front();
            hist.push_back(s);
            e_rgb = refPixel(d.video_on, modelVis(m_in_game, m_k), modelState(m_in_game, m_k), s);
            e_hs  = d.hsync;
            e_vs  = d.vsync;
            if (m_prev_vs && !s.vsync) begin
                if (!s.game_over) begin
                    m_in_game = 1'b0;
                    m_k = 0;
                end else if (!m_in_game) begin
                    m_in_game = 1'b1;
                    m_k = 0;
                end else begin
                    m_k++;
                end
            end
            m_prev_vs = s.vsync;
            e_state = modelState(m_in_game, m_k);
            if (prev_hs_in && !s.hsync) hs_fall_cyc = cyc;
        end
        prev_hs_in = s.hsync;
        #1;
        if (m_valid) begin
            checkOutput("rgb", vid.rgb, e_rgb);
            checkOutput("hsync", vid.hsync, e_hs);
            checkOutput("vsync", vid.vsync, e_vs);
            checkOutput("go_state", vid.go_state, e_state);
            if (prev_hs_out && !vid.hsync && hs_fall_cyc >= 0)
                checkOutput("hsync_latency", cyc - hs_fall_cyc, SYNC_LAT);
        end
        prev_hs_out = vid.hsync;
    end

    task automatic applyStimulus(input int x, input int y, input bit rnd);
        vid.video_on_in = (x < H_ACT) && (y < V_ACT);
        vid.hsync_in    = !(x >= 13 && x <= 14);
        vid.vsync_in    = (y != V_TOT - 1);
        if (rnd) begin
            if ($urandom_range(0, 299) == 0) go_level = ~go_level;
            vid.bg_rgb    = 12'($urandom);
            vid.coin_rgb  = 12'($urandom);
            vid.mario_rgb = 12'($urandom);
            vid.go_rgb    = 12'($urandom);
            vid.coin_on   = 1'($urandom_range(0, 1));
            vid.mario_on  = 1'($urandom_range(0, 1));
            vid.go_on     = 1'($urandom_range(0, 1));
        end else begin
            vid.bg_rgb    = fix.bg;
            vid.coin_rgb  = fix.coin;
            vid.mario_rgb = fix.mario;
            vid.go_rgb    = fix.go;
            vid.coin_on   = fix.coin_on;
            vid.mario_on  = fix.mario_on;
            vid.go_on     = fix.go_on;
        end
        vid.game_over = go_level;
    endtask

    // One full frame; vsync_in falls on the last line, so its frame start governs the next frame.
    task automatic runFrame(input bit rnd, input int drop_line, input int rst_line,
                            output logic [11:0] smp_rgb, output logic [1:0] smp_state);
        bit rst_pending;
        rst_pending = 1'b0;
        smp_rgb = 'x;
        smp_state = 'x;
        for (int y = 0; y < V_TOT; y++) begin
            for (int x = 0; x < H_TOT; x++) begin
                @(negedge clk);
                if (rst_pending) begin
                    checkOutput("midframe_reset_rgb", vid.rgb, 12'h000);
                    checkOutput("midframe_reset_hsync", vid.hsync, 1'b1);
                    checkOutput("midframe_reset_vsync", vid.vsync, 1'b1);
                    checkOutput("midframe_reset_state", vid.go_state, 2'd0);
                    rst = 1'b0;
                    rst_pending = 1'b0;
                end
                if (x == 8 && y == 4) begin
                    smp_rgb = vid.rgb;
                    smp_state = vid.go_state;
                end
                if (y == drop_line && x == 0) go_level = 1'b0;
                applyStimulus(x, y, rnd);
                if (y == rst_line && x == 5) begin
                    rst = 1'b1;
                    rst_pending = 1'b1;
                end
            end
        end
    endtask

    initial begin
        logic [11:0] r;
        logic [1:0]  st;

        tbl[0]  = mkVec(12'h3B9, 12'hFF0, 1, 12'hF00, 1, 12'hFFF, 0, 0, 12'hF00, 2'd0);
        tbl[1]  = mkVec(12'h3B9, 12'hFF0, 1, 12'hF00, 0, 12'hFFF, 0, 0, 12'hFF0, 2'd0);
        tbl[2]  = mkVec(12'h3B9, 12'hFF0, 0, 12'hF00, 0, 12'hFFF, 0, 0, 12'h3B9, 2'd0);
        tbl[3]  = mkVec(12'h3B9, 12'hFF0, 0, 12'hF00, 0, 12'hFFF, 1, 0, 12'h3B9, 2'd0);
        tbl[4]  = mkVec(12'h3B9, 12'hFF0, 0, 12'hF00, 1, 12'hFFF, 1, 1, 12'hF00, 2'd0);
        tbl[5]  = mkVec(12'h3B9, 12'hFF0, 0, 12'hF00, 0, 12'hFFF, 0, 1, BG_BLINK, 2'd1);
        tbl[6]  = mkVec(12'h3B9, 12'hFF0, 0, 12'hF00, 0, 12'hFFF, 1, 1, 12'hFFF, 2'd1);
        tbl[7]  = mkVec(12'h3B9, 12'hFF0, 0, 12'hF00, 1, 12'hFFF, 1, 1, MARIO_BLINK, 2'd1);
        tbl[8]  = mkVec(12'h3B9, 12'hFF0, 0, 12'hF00, 0, 12'hFFF, 1, 1, BG_BLINK, 2'd1);
        tbl[9]  = mkVec(12'h3B9, 12'hFF0, 0, 12'hF00, 0, 12'hFFF, 1, 1, 12'hFFF, 2'd1);
        tbl[10] = mkVec(12'h3B9, 12'hFF0, 0, 12'hF00, 0, 12'hFFF, 1, 1, 12'hFFF, 2'd1);
        tbl[11] = mkVec(12'h3B9, 12'hFF0, 0, 12'hF00, 0, 12'hFFF, 1, 1, BG_BLINK, 2'd1);
        tbl[12] = mkVec(12'h3B9, 12'hFF0, 0, 12'hF00, 0, 12'hFFF, 1, 1, BG_BLINK, 2'd1);
        tbl[13] = mkVec(12'h3B9, 12'hFF0, 0, 12'hF00, 0, 12'hFFF, 1, 1, 12'hFFF, 2'd1);
        tbl[14] = mkVec(12'h3B9, 12'hFF0, 0, 12'hF00, 0, 12'hFFF, 1, 1, 12'hFFF, 2'd1);
        tbl[15] = mkVec(12'h3B9, 12'hFF0, 0, 12'hF00, 0, 12'hFFF, 1, 1, BG_BLINK, 2'd1);
        tbl[16] = mkVec(12'h3B9, 12'hFF0, 0, 12'hF00, 0, 12'hFFF, 1, 1, BG_BLINK, 2'd1);
        tbl[17] = mkVec(12'h3B9, 12'hFF0, 0, 12'hF00, 0, 12'hFFF, 1, 1, 12'hFFF, 2'd2);
        tbl[18] = mkVec(12'h3B9, 12'hFF0, 0, 12'hF00, 0, 12'hFFF, 0, 1, BG_BLINK, 2'd2);
        tbl[19] = mkVec(12'h3B9, 12'hFF0, 0, 12'hF00, 0, 12'hFFF, 1, 1, 12'hFFF, 2'd2);

        fix = mkVec(12'h000, 12'h000, 0, 12'h000, 0, 12'h000, 0, 0, 12'h000, 2'd0);
        go_level = 1'b0;
        vid.video_on_in = 1'b0;
        vid.hsync_in = 1'b1;
        vid.vsync_in = 1'b1;
        vid.game_over = 1'b0;
        vid.bg_rgb = 12'h000;
        vid.coin_rgb = 12'h000;
        vid.mario_rgb = 12'h000;
        vid.go_rgb = 12'h000;
        vid.coin_on = 1'b0;
        vid.mario_on = 1'b0;
        vid.go_on = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("idle_rgb", vid.rgb, 12'h000);
        checkOutput("idle_hsync", vid.hsync, 1'b1);
        checkOutput("idle_vsync", vid.vsync, 1'b1);
        checkOutput("idle_state", vid.go_state, 2'd0);

        // Frame table: PLAY priorities, entry into BLINK, the blink pattern and HOLD.
        for (int i = 0; i < NV; i++) begin
            fix = tbl[i];
            go_level = tbl[i].game_over;
            runFrame(1'b0, -1, -1, r, st);
            checkOutput($sformatf("vec%0d_rgb", i), r, tbl[i].exp_rgb);
            checkOutput($sformatf("vec%0d_state", i), st, tbl[i].exp_state);
        end

        // HOLD, game_over drops mid-frame: state holds until the next frame start.
        fix = mkVec(12'h3B9, 12'hFF0, 0, 12'hF00, 0, 12'hFFF, 1, 1, 12'h000, 2'd0);
        go_level = 1'b1;
        runFrame(1'b0, 2, -1, r, st);
        checkOutput("drop_same_frame_rgb", r, 12'hFFF);
        checkOutput("drop_same_frame_state", st, 2'd2);
        runFrame(1'b0, -1, -1, r, st);
        checkOutput("drop_next_frame_rgb", r, 12'h3B9);
        checkOutput("drop_next_frame_state", st, 2'd0);

        // Reset during BLINK: overlay stays hidden until game_over is seen at a frame start.
        go_level = 1'b1;
        runFrame(1'b0, -1, -1, r, st);
        checkOutput("pre_blink_rgb", r, 12'h3B9);
        runFrame(1'b0, -1, -1, r, st);
        checkOutput("blink_rgb", r, 12'hFFF);
        checkOutput("blink_state", st, 2'd1);
        runFrame(1'b0, -1, 2, r, st);
        checkOutput("after_reset_rgb", r, 12'h3B9);
        checkOutput("after_reset_state", st, 2'd0);
        runFrame(1'b0, -1, -1, r, st);
        checkOutput("reblink_rgb", r, 12'hFFF);
        checkOutput("reblink_state", st, 2'd1);

        // Random frames against the model.
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 5) == 0) go_level = ~go_level;
            runFrame(1'b1, -1, -1, r, st);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
